// File: rtl/seven_seg_pkg.sv
// Shared types, constants and glyph table for the seven-segment display path.
package seven_seg_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} ctrl_state_t;
  typedef enum logic [1:0] {DIG_UNITS, DIG_TENS, DIG_SIGN} digit_sel_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam int         VAL_MAX   = 99;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows as blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_digit_decode.sv
// Combinational BCD digit to active-low segment pattern.
module seven_seg_digit_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = digit_to_seg(i_digit);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Accepts signed samples, converts them to sign/tens/units and scans the
// three common-anode digits over one shared segment bus.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data_in,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic [6:0] o_seg_n,
  output logic [2:0] o_an_n
);

  localparam int                CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic signed [7:0] CLAMP_HI = 8'(VAL_MAX);
  localparam logic signed [7:0] CLAMP_LO = -CLAMP_HI;

  ctrl_state_t r_state, w_nextState;
  logic        r_neg, w_nextNeg;
  logic [6:0]  r_rem, w_nextRem;
  logic [3:0]  r_tensAcc, w_nextTensAcc;
  logic        w_commit;

  logic        r_dispNeg;
  logic [3:0]  r_dispTens, r_dispUnits;

  logic signed [7:0] w_sample, w_clamped;
  logic [6:0]        w_absRem;

  logic [CNT_W-1:0] r_scanCnt;
  digit_sel_t       r_digitIdx, w_nextIdx;
  logic             w_wrap;
  logic [3:0]       w_decDigit;
  logic [6:0]       w_decSeg, w_nextSeg;
  logic [2:0]       w_nextAn;

  assign w_sample = i_data_in;

  // Negate only after clamping so -128 never has to be represented as +128.
  always_comb begin
    if (w_sample > CLAMP_HI)
      w_clamped = CLAMP_HI;
    else if (w_sample < CLAMP_LO)
      w_clamped = CLAMP_LO;
    else
      w_clamped = w_sample;
    w_absRem = w_clamped[7] ? 7'(-w_clamped) : 7'(w_clamped);
  end

  assign o_data_ready = (r_state == IDLE);

  always_comb begin
    w_nextState   = r_state;
    w_nextNeg     = r_neg;
    w_nextRem     = r_rem;
    w_nextTensAcc = r_tensAcc;
    w_commit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_data_valid) begin
          w_nextState   = CONVERT;
          w_nextNeg     = w_clamped[7];
          w_nextRem     = w_absRem;
          w_nextTensAcc = 4'd0;
        end
      end
      CONVERT: begin
        if (r_rem >= 7'd10) begin
          w_nextRem     = r_rem - 7'd10;
          w_nextTensAcc = r_tensAcc + 4'd1;
        end else begin
          w_nextState = COMMIT;
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_neg     <= 1'b0;
      r_rem     <= '0;
      r_tensAcc <= '0;
    end else begin
      r_state   <= w_nextState;
      r_neg     <= w_nextNeg;
      r_rem     <= w_nextRem;
      r_tensAcc <= w_nextTensAcc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dispNeg   <= 1'b0;
      r_dispTens  <= '0;
      r_dispUnits <= '0;
    end else if (w_commit) begin
      r_dispNeg   <= r_neg;
      r_dispTens  <= r_tensAcc;
      r_dispUnits <= r_rem[3:0];
    end
  end

  assign w_wrap = (r_scanCnt == CNT_LAST);

  always_comb begin
    w_nextIdx = r_digitIdx;
    if (w_wrap) begin
      case (r_digitIdx)
        DIG_UNITS: w_nextIdx = DIG_TENS;
        DIG_TENS:  w_nextIdx = DIG_SIGN;
        default:   w_nextIdx = DIG_UNITS;
      endcase
    end
  end

  // Patterns are built for the slot being entered so an_n and seg_n always move together.
  always_comb begin
    w_decDigit = r_dispUnits;
    w_nextAn   = 3'b110;
    case (w_nextIdx)
      DIG_TENS: begin
        w_decDigit = (BLANK_LZ && r_dispTens == 4'd0) ? 4'hF : r_dispTens;
        w_nextAn   = 3'b101;
      end
      DIG_SIGN: w_nextAn = 3'b011;
      default:  w_nextAn = 3'b110;
    endcase
  end

  seven_seg_digit_decode u_decode (
    .i_digit (w_decDigit),
    .o_seg_n (w_decSeg)
  );

  assign w_nextSeg = (w_nextIdx == DIG_SIGN) ? (r_dispNeg ? SEG_MINUS : SEG_BLANK) : w_decSeg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scanCnt  <= '0;
      r_digitIdx <= DIG_UNITS;
      o_an_n     <= 3'b110;
      o_seg_n    <= 7'b1000000;
    end else begin
      r_scanCnt  <= w_wrap ? '0 : r_scanCnt + 1'b1;
      r_digitIdx <= w_nextIdx;
      o_an_n     <= w_nextAn;
      o_seg_n    <= w_nextSeg;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: accepted samples queue their expected display value, and a
// negedge monitor checks scan, segments and ready against a decimal reference.
module tb_seven_seg_scan_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dataIn = 8'd0;
  logic       dataValid = 1'b0;

  logic       dataReady, dataReady0;
  logic [6:0] segN, segN0;
  logic [2:0] anN, anN0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_in    (dataIn),
    .i_data_valid (dataValid),
    .o_data_ready (dataReady),
    .o_seg_n      (segN),
    .o_an_n       (anN)
  );

  seven_seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dutNoBlank (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_in    (dataIn),
    .i_data_valid (dataValid),
    .o_data_ready (dataReady0),
    .o_seg_n      (segN0),
    .o_an_n       (anN0)
  );

  typedef struct {
    int due;
    bit neg;
    int tens;
    int units;
  } disp_t;

  disp_t      pending[$];
  disp_t      curDisp = '{due: 0, neg: 1'b0, tens: 0, units: 0};
  int         edgeCnt;
  int         busyUntil = 0;
  int         compared = 0;
  int         mismatched = 0;
  int         monK, monSlot;
  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always @(posedge clk or posedge rst) begin
    if (rst) edgeCnt <= 0;
    else     edgeCnt <= edgeCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] expSeg(input int slot, input disp_t d, input bit blank);
    if (slot == 0) return glyph[d.units];
    if (slot == 1) return (blank && d.tens == 0) ? 7'h7F : glyph[d.tens];
    return d.neg ? 7'h3F : 7'h7F;
  endfunction

  function automatic logic [6:0] expAn(input int slot);
    if (slot == 0) return 7'(3'b110);
    if (slot == 1) return 7'(3'b101);
    return 7'(3'b011);
  endfunction

  // Segments after edge k show the slot entered at edge k using the value held before it.
  always @(negedge clk) begin
    if (!rst) begin
      monK = edgeCnt;
      while (pending.size() > 0 && pending[0].due <= monK - 1)
        curDisp = pending.pop_front();
      monSlot = (monK / DIV) % 3;
      checkOutput("an_n", 7'(anN), expAn(monSlot));
      checkOutput("an_n_noblank", 7'(anN0), expAn(monSlot));
      checkOutput("seg_n", segN, expSeg(monSlot, curDisp, 1'b1));
      checkOutput("seg_n_noblank", segN0, expSeg(monSlot, curDisp, 1'b0));
      checkOutput("data_ready", 7'(dataReady), 7'(monK >= busyUntil));
      checkOutput("data_ready_noblank", 7'(dataReady0), 7'(monK >= busyUntil));
    end
  end

  task automatic waitDrive();
    @(negedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    dataValid = 1'b0;
    dataIn    = 8'($urandom);
    repeat (n) waitDrive();
  endtask

  // Holds valid until the reference says the block is ready, then books the result.
  task automatic applyStimulus(input logic [7:0] v);
    int  s, a, accEdge;
    bit  done;
    done      = 1'b0;
    dataIn    = v;
    dataValid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (edgeCnt >= busyUntil) begin
        s = int'($signed(v));
        if (s > 99)  s = 99;
        if (s < -99) s = -99;
        a       = (s < 0) ? -s : s;
        accEdge = edgeCnt + 1;
        pending.push_back('{due: accEdge + a / 10 + 2, neg: (s < 0), tens: a / 10, units: a % 10});
        busyUntil = accEdge + a / 10 + 2;
        done      = 1'b1;
      end
      waitDrive();
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: sample %0d not accepted within 40 cycles", $signed(v));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    waitDrive();
    checkOutput("reset_an_n", 7'(anN), 7'(3'b110));
    checkOutput("reset_seg_n", segN, 7'b1000000);
    checkOutput("reset_ready", 7'(dataReady), 7'd1);
    rst = 1'b0;

    idleCycles(20);

    applyStimulus(8'd42);   idleCycles(14);
    applyStimulus(8'hF9);   idleCycles(14);
    applyStimulus(8'h80);   idleCycles(14);
    applyStimulus(8'd127);  idleCycles(14);
    applyStimulus(8'd100);  idleCycles(14);

    applyStimulus(8'd55);
    applyStimulus(8'd13);
    idleCycles(14);

    foreach (glyph[i]) begin
      applyStimulus(8'(i * 11 - 50));
      idleCycles(2);
    end
    applyStimulus(8'd0);   idleCycles(13);
    applyStimulus(8'd9);   idleCycles(13);
    applyStimulus(8'd10);  idleCycles(13);
    applyStimulus(8'h9D);  idleCycles(13);
    applyStimulus(8'h9C);  idleCycles(13);

    for (int i = 0; i < 40; i++) begin
      int gap;
      applyStimulus(8'($urandom_range(0, 255)));
      gap = $urandom_range(0, 14);
      if (gap > 0) idleCycles(gap);
    end
    idleCycles(14);

    applyStimulus(8'd90);
    dataValid = 1'b0;
    repeat (4) waitDrive();
    #1;
    rst = 1'b1;
    #1;
    pending.delete();
    busyUntil = 0;
    curDisp   = '{due: 0, neg: 1'b0, tens: 0, units: 0};
    checkOutput("midreset_an_n", 7'(anN), 7'(3'b110));
    checkOutput("midreset_seg_n", segN, 7'b1000000);
    checkOutput("midreset_ready", 7'(dataReady), 7'd1);
    checkOutput("midreset_seg_n_noblank", segN0, 7'b1000000);
    repeat (3) waitDrive();
    rst = 1'b0;
    idleCycles(30);

    applyStimulus(8'd37);
    idleCycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
